count_seq_monitor: RTL and testbench

- Downstream consumer of the 4-bit up counter's `count[3:0]` and `upper` outputs.
- Each enabled cycle it checks that the count advances by exactly +1 modulo 16 and that `upper` equals `count[3]`.
- It flags upper-half entry and wrap events and accumulates the number of wraps.
- It feeds the lab status/display logic and catches counter or wiring faults.

---
 rtl/count_seq_monitor.sv | 120 ++++++++++++
 tb/tb_count_seq_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// Sequence monitor for a 4-bit up counter: checks +1 mod 16 stepping and the
// upper flag, flags upper-half entry and wrap events, and counts wraps.
module count_seq_monitor #(
   parameter int WRAP_W      = 8,
   parameter bit CHECK_UPPER = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [3:0]        cnt_in,
   input  logic              upper_in,
   input  logic              clr_err,
   output logic              in_upper,
   output logic              rise_pulse,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wraps,
   output logic              seq_err,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t            st_q, st_d;
   logic [3:0]        prev_q, prev_d;
   logic              in_upper_q, in_upper_d;
   logic              rise_q, rise_d;
   logic              wrap_q, wrap_d;
   logic [WRAP_W-1:0] wraps_q, wraps_d;
   logic              err_q, err_d;
   logic [3:0]        exp_cnt;
   logic              cons_fault;

   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
      if (&v) return v;
      return v + {{(WRAP_W-1){1'b0}}, 1'b1};
   endfunction

   assign exp_cnt    = prev_q + 4'd1;
   assign cons_fault = CHECK_UPPER && (upper_in != cnt_in[3]);

   always_comb begin
      st_d       = st_q;
      prev_d     = prev_q;
      in_upper_d = in_upper_q;
      rise_d     = 1'b0;
      wrap_d     = 1'b0;
      wraps_d    = wraps_q;
      err_d      = err_q;
      if (clr_err) begin
         // Clear wins over any sample presented in the same cycle.
         st_d  = SYNC;
         err_d = 1'b0;
      end else if (en) begin
         unique case (st_q)
            SYNC: begin
               if (cons_fault) begin
                  st_d  = ERR;
                  err_d = 1'b1;
               end else begin
                  prev_d     = cnt_in;
                  in_upper_d = cnt_in[3];
                  st_d       = cnt_in[3] ? HIGH : LOW;
               end
            end
            LOW, HIGH: begin
               if ((cnt_in != exp_cnt) || cons_fault) begin
                  st_d  = ERR;
                  err_d = 1'b1;
               end else begin
                  prev_d     = cnt_in;
                  in_upper_d = cnt_in[3];
                  if (st_q == LOW && cnt_in == 4'd8) begin
                     rise_d = 1'b1;
                     st_d   = HIGH;
                  end else if (st_q == HIGH && cnt_in == 4'd0) begin
                     wrap_d  = 1'b1;
                     wraps_d = sat_inc(wraps_q);
                     st_d    = LOW;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= SYNC;
         prev_q     <= 4'd0;
         in_upper_q <= 1'b0;
         rise_q     <= 1'b0;
         wrap_q     <= 1'b0;
         wraps_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         st_q       <= st_d;
         prev_q     <= prev_d;
         in_upper_q <= in_upper_d;
         rise_q     <= rise_d;
         wrap_q     <= wrap_d;
         wraps_q    <= wraps_d;
         err_q      <= err_d;
      end
   end

   assign in_upper   = in_upper_q;
   assign rise_pulse = rise_q;
   assign wrap_pulse = wrap_q;
   assign wraps      = wraps_q;
   assign seq_err    = err_q;
   assign state      = st_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench for count_seq_monitor: default, CHECK_UPPER=0 and WRAP_W=2
// instances share stimulus; a monitor pops expected outputs each cycle.
module tb_count_seq_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] cnt_in = 4'd0;
   logic       upper_in = 1'b0;
   logic       clr_err = 1'b0;

   logic       iu_a, rp_a, wp_a, err_a;
   logic [7:0] wr_a;
   logic [1:0] st_a;
   logic       iu_b, rp_b, wp_b, err_b;
   logic [7:0] wr_b;
   logic [1:0] st_b;
   logic       iu_c, rp_c, wp_c, err_c;
   logic [1:0] wr_c;
   logic [1:0] st_c;

   always #5 clk = ~clk;

   count_seq_monitor #(.WRAP_W(8), .CHECK_UPPER(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in), .upper_in(upper_in),
      .clr_err(clr_err), .in_upper(iu_a), .rise_pulse(rp_a), .wrap_pulse(wp_a),
      .wraps(wr_a), .seq_err(err_a), .state(st_a));

   count_seq_monitor #(.WRAP_W(8), .CHECK_UPPER(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in), .upper_in(upper_in),
      .clr_err(clr_err), .in_upper(iu_b), .rise_pulse(rp_b), .wrap_pulse(wp_b),
      .wraps(wr_b), .seq_err(err_b), .state(st_b));

   count_seq_monitor #(.WRAP_W(2), .CHECK_UPPER(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in), .upper_in(upper_in),
      .clr_err(clr_err), .in_upper(iu_c), .rise_pulse(rp_c), .wrap_pulse(wp_c),
      .wraps(wr_c), .seq_err(err_c), .state(st_c));

   typedef struct {
      int st;
      int prev;
      int iu;
      int rp;
      int wp;
      int err;
      int wr;
   } mdl_t;

   typedef struct {
      mdl_t a;
      mdl_t b;
      mdl_t c;
   } exp_t;

   exp_t q[$];
   mdl_t ma, mb, mc;
   int   tests = 0;
   int   failed = 0;
   int   rises_a = 0;
   int   wraps_seen_a = 0;
   int   wraps_seen_c = 0;

   // Reference behaviour: the state follows the half of the last accepted value.
   function automatic mdl_t mstep(mdl_t m, logic e, logic [3:0] c, logic u,
                                  logic clr, bit chk, int wmax);
      mdl_t n;
      logic [3:0] nxt;
      n = m;
      n.rp = 0;
      n.wp = 0;
      nxt = 4'(m.prev + 1);
      if (clr) begin
         n.st  = 0;
         n.err = 0;
      end else if (e && m.st != 3) begin
         if ((chk && (u != c[3])) || (m.st != 0 && c != nxt)) begin
            n.st  = 3;
            n.err = 1;
         end else begin
            if (m.st == 1 && c == 4'd8) n.rp = 1;
            if (m.st == 2 && c == 4'd0) begin
               n.wp = 1;
               if (n.wr < wmax) n.wr = n.wr + 1;
            end
            n.prev = int'(c);
            n.iu   = int'(c[3]);
            n.st   = c[3] ? 2 : 1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ma = '{default: 0};
      mb = '{default: 0};
      mc = '{default: 0};
   endtask

   task automatic step(input logic e, input logic [3:0] c, input logic u, input logic clr);
      exp_t x;
      @(negedge clk);
      en = e; cnt_in = c; upper_in = u; clr_err = clr;
      ma = mstep(ma, e, c, u, clr, 1'b1, 255);
      mb = mstep(mb, e, c, u, clr, 1'b0, 255);
      mc = mstep(mc, e, c, u, clr, 1'b1, 3);
      x.a = ma; x.b = mb; x.c = mc;
      q.push_back(x);
   endtask

   task automatic cnt(input int v);
      logic [3:0] c;
      c = v[3:0];
      step(1'b1, c, c[3], 1'b0);
   endtask

   task automatic drain();
      step(1'b0, 4'd0, 1'b0, 1'b0);
      for (int n = 0; n < 8 && q.size() > 0; n++) begin
         @(posedge clk);
         #2;
      end
      if (q.size() != 0) begin
         tests++;
         failed++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: one expected entry per clock edge while stimulus is outstanding.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("a.state", int'(st_a), e.a.st);
            chk("a.in_upper", int'(iu_a), e.a.iu);
            chk("a.rise_pulse", int'(rp_a), e.a.rp);
            chk("a.wrap_pulse", int'(wp_a), e.a.wp);
            chk("a.seq_err", int'(err_a), e.a.err);
            chk("a.wraps", int'(wr_a), e.a.wr);
            chk("b.state", int'(st_b), e.b.st);
            chk("b.seq_err", int'(err_b), e.b.err);
            chk("c.wraps", int'(wr_c), e.c.wr);
            chk("c.wrap_pulse", int'(wp_c), e.c.wp);
            if (rp_a) rises_a++;
            if (wp_a) wraps_seen_a++;
            if (wp_c) wraps_seen_c++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      #12;
      chk("rst.state", int'(st_a), 0);
      chk("rst.seq_err", int'(err_a), 0);
      chk("rst.wraps", int'(wr_a), 0);
      chk("rst.in_upper", int'(iu_a), 0);
      chk("rst.pulses", int'(rp_a) + int'(wp_a), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Free-running counter, 40 samples from 0
      for (int i = 0; i < 40; i++) cnt(i);
      drain();
      chk("run40.rises", rises_a, 2);
      chk("run40.wrap_pulses", wraps_seen_a, 2);
      chk("run40.wraps", int'(wr_a), 2);
      chk("run40.seq_err", int'(err_a), 0);
      chk("run40.state", int'(st_a), 1);

      // 80 more samples: five more wraps, narrow accumulator saturates
      wraps_seen_c = 0;
      for (int i = 40; i < 120; i++) cnt(i);
      drain();
      chk("sat.c_wraps", int'(wr_c), 3);
      chk("sat.c_wrap_pulses", wraps_seen_c, 5);
      chk("sat.a_wraps", int'(wr_a), 7);

      // Skip 3,4,6 -> ERR, frozen wraps, then clear
      step(1'b0, 4'd0, 1'b0, 1'b1);
      cnt(3); cnt(4); cnt(6);
      drain();
      chk("skip.state", int'(st_a), 3);
      chk("skip.seq_err", int'(err_a), 1);
      cnt(7); cnt(15); cnt(0);
      drain();
      chk("err.wraps_frozen", int'(wr_a), 7);
      chk("err.state_hold", int'(st_a), 3);
      step(1'b0, 4'd0, 1'b0, 1'b1);
      drain();
      chk("clr.state", int'(st_a), 0);
      chk("clr.seq_err", int'(err_a), 0);
      chk("clr.wraps", int'(wr_a), 7);

      // Upper flag inconsistent: only the checking instance errors
      step(1'b1, 4'd9, 1'b0, 1'b0);
      drain();
      chk("cons.a_state", int'(st_a), 3);
      chk("cons.a_seq_err", int'(err_a), 1);
      chk("cons.b_state", int'(st_b), 2);
      chk("cons.b_seq_err", int'(err_b), 0);
      step(1'b0, 4'd0, 1'b0, 1'b1);

      // en gaps are legal; then a held value is a skip
      rises_a = 0;
      cnt(5); cnt(6);
      step(1'b0, 4'd13, 1'b1, 1'b0);
      step(1'b0, 4'd2, 1'b0, 1'b0);
      cnt(7); cnt(8);
      drain();
      chk("gap.seq_err", int'(err_a), 0);
      chk("gap.state", int'(st_a), 2);
      chk("gap.rises", rises_a, 1);
      cnt(8);
      drain();
      chk("hold.seq_err", int'(err_a), 1);

      // Clear beats a simultaneous sample
      step(1'b1, 4'd9, 1'b1, 1'b1);
      drain();
      chk("clrprio.state", int'(st_a), 0);

      // Asynchronous reset while in HIGH
      cnt(10); cnt(11); cnt(12);
      drain();
      chk("pre_rst.state", int'(st_a), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.state", int'(st_a), 0);
      chk("arst.in_upper", int'(iu_a), 0);
      chk("arst.wraps", int'(wr_a), 0);
      chk("arst.seq_err", int'(err_a), 0);
      chk("arst.pulses", int'(rp_a) + int'(wp_a), 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cnt(11);
      drain();
      chk("post_rst.state", int'(st_a), 2);
      chk("post_rst.in_upper", int'(iu_a), 1);
      chk("post_rst.wraps", int'(wr_a), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
